systolic_array_controller: RTL

Sequencer for the weight-stationary `systolic_array`. It latches a weight matrix on `start_in` and loads it into the array. It then streams a batch of activation vectors through a valid/ready handshake, applying per-row input skew. It de-skews the per-column sums back into whole result vectors and signals completion. It sits between the activation/weight buffers and the array and owns all array timing, so upstream logic only sees vector-level handshakes.

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/skew_buffer.sv | 34 +++
 rtl/systolic_array_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array controller and its skew buffers.
package systolic_pkg;

    localparam int unsigned SA_ROWS        = 8;
    localparam int unsigned SA_COLS        = 8;
    localparam int unsigned SA_W           = 16;
    localparam int unsigned SA_LAT         = 8;
    localparam int unsigned SA_MAX_VECTORS = 256;
    localparam int unsigned SA_CNT_W       = $clog2(SA_MAX_VECTORS + 1);

    localparam bit SKEW_ASCENDING  = 1'b0;
    localparam bit SKEW_DESCENDING = 1'b1;

    typedef logic [SA_CNT_W-1:0] sa_count_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } sa_ctrl_state_t;

    function automatic int unsigned skew_depth(input int unsigned lanes, input int unsigned base,
                                               input int unsigned lane, input bit descending);
        return descending ? base + lanes - 1 - lane : base + lane;
    endfunction

endpackage

// File: rtl/skew_buffer.sv
// Per-lane delay lines whose depth grows (ascending) or shrinks (descending) with lane index.
module skew_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned LANES      = 8,
    parameter int unsigned W          = 16,
    parameter int unsigned BASE_DEPTH = 1,
    parameter bit          DIRECTION  = SKEW_ASCENDING
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES*W-1:0] src,
    output logic [LANES*W-1:0] dst
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int unsigned Depth = skew_depth(LANES, BASE_DEPTH, i, DIRECTION);
        typedef logic [Depth*W-1:0] pipe_t;

        pipe_t pipe_q;

        // Newest sample enters at the bottom; the cast drops the oldest word off the top.
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_t'({pipe_q, src[i*W +: W]});
            end
        end

        assign dst[i*W +: W] = pipe_q[Depth*W-1 -: W];
    end

endmodule

// File: rtl/systolic_array_controller.sv
// Job sequencer for a weight-stationary systolic array: weight load, skewed activation
// streaming, token-tracked result de-skew and completion signalling.
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int unsigned SYSTOLIC_ARRAY_ROWS = SA_ROWS,
    parameter int unsigned SYSTOLIC_ARRAY_COLS = SA_COLS,
    parameter int unsigned FIXED_POINT_WIDTH   = SA_W,
    parameter int unsigned SA_LATENCY          = SA_LAT,
    parameter int unsigned MAX_VECTORS         = SA_MAX_VECTORS
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic start_in,
    input  logic [SYSTOLIC_ARRAY_ROWS*SYSTOLIC_ARRAY_COLS*FIXED_POINT_WIDTH-1:0] weights_in,
    input  logic [$clog2(MAX_VECTORS+1)-1:0] vector_count_in,
    input  logic act_valid_in,
    output logic act_ready_out,
    input  logic [SYSTOLIC_ARRAY_ROWS*FIXED_POINT_WIDTH-1:0] act_data_in,
    output logic sa_weights_valid_out,
    output logic [SYSTOLIC_ARRAY_ROWS*SYSTOLIC_ARRAY_COLS*FIXED_POINT_WIDTH-1:0] sa_weights_out,
    output logic [SYSTOLIC_ARRAY_ROWS*FIXED_POINT_WIDTH-1:0] sa_activations_out,
    input  logic [SYSTOLIC_ARRAY_COLS*FIXED_POINT_WIDTH-1:0] sa_sum_in,
    output logic result_valid_out,
    output logic [SYSTOLIC_ARRAY_COLS*FIXED_POINT_WIDTH-1:0] result_data_out,
    output logic busy_out,
    output logic done_out
);

    localparam int unsigned Rows   = SYSTOLIC_ARRAY_ROWS;
    localparam int unsigned Cols   = SYSTOLIC_ARRAY_COLS;
    localparam int unsigned W      = FIXED_POINT_WIDTH;
    localparam int unsigned CntW   = $clog2(MAX_VECTORS + 1);
    localparam int unsigned TokLen = 1 + SA_LATENCY + Cols;

    sa_ctrl_state_t state_q, state_d;

    logic [Rows*Cols*W-1:0] weights_q;
    logic [CntW-1:0]        count_q;
    logic [CntW-1:0]        accepted_q;
    logic [CntW-1:0]        emitted_q;
    logic [TokLen-1:0]      tok_q;
    logic [CntW:0]          emitted_sum;
    logic [Rows*W-1:0]      skew_src;
    logic                   accept;
    logic                   start_ok;
    logic                   drain_done;

    assign accept     = act_valid_in & act_ready_out;
    assign start_ok   = (state_q == StIdle) & start_in;
    // Counting the strobe of this cycle lets DONE follow the last result by exactly one cycle.
    assign emitted_sum = {1'b0, emitted_q} + {{CntW{1'b0}}, result_valid_out};
    assign drain_done  = (emitted_sum == {1'b0, count_q});

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_in) state_d = StLoad;
            StLoad:   state_d = (count_q == '0) ? StDone : StStream;
            StStream: if (accepted_q == count_q) state_d = StDrain;
            StDrain:  if (drain_done) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        act_ready_out        = (state_q == StStream) && (accepted_q != count_q);
        sa_weights_valid_out = (state_q == StLoad);
        busy_out             = (state_q != StIdle);
        done_out             = (state_q == StDone);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            weights_q  <= '0;
            count_q    <= '0;
            accepted_q <= '0;
            emitted_q  <= '0;
            tok_q      <= '0;
        end else begin
            tok_q <= {tok_q[TokLen-2:0], accept};
            if (accept) begin
                accepted_q <= accepted_q + CntW'(1);
            end
            if (result_valid_out) begin
                emitted_q <= emitted_q + CntW'(1);
            end
            if (start_ok) begin
                weights_q  <= weights_in;
                count_q    <= vector_count_in;
                accepted_q <= '0;
                emitted_q  <= '0;
            end
        end
    end

    assign sa_weights_out   = weights_q;
    assign result_valid_out = tok_q[TokLen-1];
    // Bubbles feed zeros so the array never sees stale activations.
    assign skew_src         = accept ? act_data_in : '0;

    skew_buffer #(
        .LANES      (Rows),
        .W          (W),
        .BASE_DEPTH (1),
        .DIRECTION  (SKEW_ASCENDING)
    ) u_in_skew (
        .clk (clk_in),
        .rst (rst_in),
        .src (skew_src),
        .dst (sa_activations_out)
    );

    skew_buffer #(
        .LANES      (Cols),
        .W          (W),
        .BASE_DEPTH (1),
        .DIRECTION  (SKEW_DESCENDING)
    ) u_out_deskew (
        .clk (clk_in),
        .rst (rst_in),
        .src (sa_sum_in),
        .dst (result_data_out)
    );

endmodule
